// File: rtl/cfu_cmd_sequencer_if.sv
// CFU command/response bus plus the A/B source and C result streams
// seen by the matmul command sequencer.
interface cfu_cmd_sequencer_if;
  logic        src_valid;
  logic        src_ready;
  logic [31:0] src_data;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [9:0]  cmd_payload_function_id;
  logic [31:0] cmd_payload_inputs_0;
  logic [31:0] cmd_payload_inputs_1;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_payload_outputs_0;

  modport master (
    input  src_valid, src_data,
    output src_ready,
    output res_valid, res_data,
    input  res_ready,
    output cmd_valid, cmd_payload_function_id, cmd_payload_inputs_0, cmd_payload_inputs_1,
    input  cmd_ready,
    input  rsp_valid, rsp_payload_outputs_0,
    output rsp_ready
  );

  modport slave (
    output src_valid, src_data,
    input  src_ready,
    input  res_valid, res_data,
    output res_ready,
    input  cmd_valid, cmd_payload_function_id, cmd_payload_inputs_0, cmd_payload_inputs_1,
    output cmd_ready,
    output rsp_valid, rsp_payload_outputs_0,
    input  rsp_ready
  );
endinterface

// File: rtl/cfu_cmd_sequencer.sv
// Matmul job sequencer: issues RESET, WRITE_MEM (A, B), COMPUTE and READ_MEM
// to the CFU one command at a time and streams READ_MEM results out.
module cfu_cmd_sequencer #(
  parameter int unsigned ADDR_BITS      = 12,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [7:0]           m_dim,
  input  logic [7:0]           k_dim,
  input  logic [7:0]           n_dim,
  input  logic [ADDR_BITS-1:0] a_count,
  input  logic [ADDR_BITS-1:0] b_count,
  input  logic [ADDR_BITS-1:0] c_count,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  cfu_cmd_sequencer_if.master  bus
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  // Command states are odd; each response state is its command state + 1.
  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_RST_C = 4'd1;
  localparam logic [3:0] S_RST_R = 4'd2;
  localparam logic [3:0] S_WRA_C = 4'd3;
  localparam logic [3:0] S_WRA_R = 4'd4;
  localparam logic [3:0] S_WRB_C = 4'd5;
  localparam logic [3:0] S_WRB_R = 4'd6;
  localparam logic [3:0] S_CMP_C = 4'd7;
  localparam logic [3:0] S_CMP_R = 4'd8;
  localparam logic [3:0] S_RD_C  = 4'd9;
  localparam logic [3:0] S_RD_R  = 4'd10;
  localparam logic [3:0] S_DONE  = 4'd11;

  localparam logic [9:0] FID_RST = {7'h00, 3'd0};
  localparam logic [9:0] FID_WRA = {7'h00, 3'd1};
  localparam logic [9:0] FID_WRB = {7'h20, 3'd1};
  localparam logic [9:0] FID_CMP = {7'h00, 3'd2};
  localparam logic [9:0] FID_RD  = {7'h00, 3'd3};

  logic [3:0]           state;
  logic [7:0]           m_q, k_q, n_q;
  logic [ADDR_BITS-1:0] a_q, b_q, c_q;
  logic [ADDR_BITS-1:0] idx;
  logic [ADDR_BITS-1:0] idx_nx;
  logic [TW-1:0]        tmo;
  logic                 cmd_valid_q;
  logic [9:0]           fid_q;
  logic [31:0]          in0_q, in1_q;
  logic                 err_q;
  logic                 res_valid_q;
  logic [31:0]          res_data_q;
  logic                 is_r, is_wr_c;
  logic                 rsp_ready_c, rsp_hs, cmd_hs, src_hs, tmo_hit;
  logic [31:0]          cmp_in1;

  // Handshake and state-decode helpers.
  always_comb begin
    is_r        = (state == S_RST_R) || (state == S_WRA_R) || (state == S_WRB_R) ||
                  (state == S_CMP_R) || (state == S_RD_R);
    is_wr_c     = (state == S_WRA_C) || (state == S_WRB_C);
    rsp_ready_c = is_r && ((state != S_RD_R) || !res_valid_q);
    rsp_hs      = bus.rsp_valid && rsp_ready_c;
    cmd_hs      = cmd_valid_q && bus.cmd_ready;
    src_hs      = bus.src_valid && is_wr_c && !cmd_valid_q;
    tmo_hit     = is_r && !bus.rsp_valid && (tmo == TW'(TIMEOUT_CYCLES - 1));
    idx_nx      = idx + 1'b1;
    cmp_in1     = {8'h00, k_q, 8'h00, n_q};
  end

  assign busy                        = (state != S_IDLE);
  assign done                        = (state == S_DONE);
  assign err                         = err_q;
  assign bus.src_ready               = is_wr_c && !cmd_valid_q;
  assign bus.rsp_ready               = rsp_ready_c;
  assign bus.cmd_valid               = cmd_valid_q;
  assign bus.cmd_payload_function_id = fid_q;
  assign bus.cmd_payload_inputs_0    = in0_q;
  assign bus.cmd_payload_inputs_1    = in1_q;
  assign bus.res_valid               = res_valid_q;
  assign bus.res_data                = res_data_q;

  // Job sequencing: command issue, phase advance, response timeout.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      m_q         <= '0;
      k_q         <= '0;
      n_q         <= '0;
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= '0;
      idx         <= '0;
      tmo         <= '0;
      cmd_valid_q <= 1'b0;
      fid_q       <= '0;
      in0_q       <= '0;
      in1_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      // Only non-response states precede a response state, so this also
      // zeroes the counter on every entry.
      tmo <= is_r ? (bus.rsp_valid ? tmo : tmo + 1'b1) : '0;
      if (tmo_hit) begin
        err_q <= 1'b1;
        state <= S_DONE;
      end else begin
        case (state)
          S_IDLE: if (start) begin
            m_q <= m_dim; k_q <= k_dim; n_q <= n_dim;
            a_q <= a_count; b_q <= b_count; c_q <= c_count;
            err_q <= 1'b0;
            idx <= '0;
            state <= S_RST_C;
            cmd_valid_q <= 1'b1;
            fid_q <= FID_RST; in0_q <= '0; in1_q <= '0;
          end
          S_RST_C, S_CMP_C, S_RD_C: if (cmd_hs) begin
            cmd_valid_q <= 1'b0;
            state <= state + 4'd1;
          end
          S_WRA_C, S_WRB_C: begin
            if (src_hs) begin
              cmd_valid_q <= 1'b1;
              fid_q <= (state == S_WRB_C) ? FID_WRB : FID_WRA;
              in0_q <= 32'(idx);
              in1_q <= bus.src_data;
            end else if (cmd_hs) begin
              cmd_valid_q <= 1'b0;
              state <= state + 4'd1;
            end
          end
          S_RST_R: if (rsp_hs) begin
            idx <= '0;
            if (a_q != '0) state <= S_WRA_C;
            else if (b_q != '0) state <= S_WRB_C;
            else begin
              state <= S_CMP_C; cmd_valid_q <= 1'b1;
              fid_q <= FID_CMP; in0_q <= {24'h0, m_q}; in1_q <= cmp_in1;
            end
          end
          S_WRA_R: if (rsp_hs) begin
            if (idx_nx == a_q) begin
              idx <= '0;
              if (b_q != '0) state <= S_WRB_C;
              else begin
                state <= S_CMP_C; cmd_valid_q <= 1'b1;
                fid_q <= FID_CMP; in0_q <= {24'h0, m_q}; in1_q <= cmp_in1;
              end
            end else begin
              idx <= idx_nx;
              state <= S_WRA_C;
            end
          end
          S_WRB_R: if (rsp_hs) begin
            if (idx_nx == b_q) begin
              idx <= '0;
              state <= S_CMP_C; cmd_valid_q <= 1'b1;
              fid_q <= FID_CMP; in0_q <= {24'h0, m_q}; in1_q <= cmp_in1;
            end else begin
              idx <= idx_nx;
              state <= S_WRB_C;
            end
          end
          S_CMP_R: if (rsp_hs) begin
            if (c_q != '0) begin
              state <= S_RD_C; cmd_valid_q <= 1'b1;
              fid_q <= FID_RD; in0_q <= '0; in1_q <= '0;
            end else begin
              state <= S_DONE;
            end
          end
          S_RD_R: if (rsp_hs) begin
            if (idx_nx == c_q) state <= S_DONE;
            else begin
              idx <= idx_nx;
              state <= S_RD_C; cmd_valid_q <= 1'b1;
              fid_q <= FID_RD; in0_q <= 32'(idx_nx); in1_q <= '0;
            end
          end
          S_DONE: state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  // Single-entry result buffer; drains independently of the job state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
    end else if ((state == S_RD_R) && rsp_hs) begin
      res_valid_q <= 1'b1;
      res_data_q  <= bus.rsp_payload_outputs_0;
    end else if (res_valid_q && bus.res_ready) begin
      res_valid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cfu_cmd_sequencer.sv
// Bench for cfu_cmd_sequencer: CFU responder, source/result stream models
// and a command/result scoreboard driven by a job table plus corner cases.
module tb_cfu_cmd_sequencer;
  localparam int unsigned AB  = 12;
  localparam int unsigned TMO = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [7:0]    m_dim = '0, k_dim = '0, n_dim = '0;
  logic [AB-1:0] a_count = '0, b_count = '0, c_count = '0;
  logic          busy, done, err;

  cfu_cmd_sequencer_if bus ();

  cfu_cmd_sequencer #(.ADDR_BITS(AB), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .start(start),
    .m_dim(m_dim), .k_dim(k_dim), .n_dim(n_dim),
    .a_count(a_count), .b_count(b_count), .c_count(c_count),
    .busy(busy), .done(done), .err(err), .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned a, b, c;
    logic [7:0]  m, k, n;
    int          mute;
    bit          exp_err;
  } job_t;

  job_t jobs[7];

  int total = 0, bad = 0;
  logic [73:0] exp_cmd[$];
  logic [31:0] src_q[$], rd_q[$], exp_res[$];
  int   cyc_n = 0, n_cmds = 0, done_cnt = 0, done_cyc = 0, last_hs_cyc = 0;
  int   mute_fid = -1, stall_at = -1, stall_left = 0, res_hold = 0;
  bit   cmd_hs, rsp_hs, src_hs, res_hs, rsp_owed, muted_hit, res_stall_arm;
  logic [73:0] got_cmd;
  logic [31:0] got_res, rsp_word, junk;
  logic [2:0]  last_op = '0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: settle effects of the last posedge, drive inputs, then note
  // which handshakes the next posedge will complete.
  task automatic tick();
    @(negedge clk);
    cyc_n++;
    if (cmd_hs) begin
      n_cmds++;
      last_hs_cyc = cyc_n;
      last_op = got_cmd[66:64];
      if (exp_cmd.size() == 0) begin
        total++; bad++;
        $display("FAIL cmd_unexpected: got %0h expected none", got_cmd);
      end else check("cmd", got_cmd, exp_cmd.pop_front());
      if (int'(got_cmd[73:64]) == mute_fid) muted_hit = 1'b1;
      else begin
        rsp_owed = 1'b1;
        if (got_cmd[66:64] == 3'd3 && rd_q.size() > 0) rsp_word = rd_q.pop_front();
        else rsp_word = $urandom;
      end
    end
    if (rsp_hs) bus.rsp_valid = 1'b0;
    if (src_hs) junk = src_q.pop_front();
    if (res_hs) begin
      if (exp_res.size() == 0) begin
        total++; bad++;
        $display("FAIL res_unexpected: got %0h expected none", got_res);
      end else check("res_data", got_res, exp_res.pop_front());
      if (res_stall_arm) begin res_hold = 4; res_stall_arm = 1'b0; end
    end
    if (rsp_owed) begin
      bus.rsp_valid = 1'b1;
      bus.rsp_payload_outputs_0 = rsp_word;
      rsp_owed = 1'b0;
    end
    bus.src_valid = (src_q.size() > 0);
    bus.src_data  = (src_q.size() > 0) ? src_q[0] : 32'h0;
    if (bus.cmd_valid && n_cmds == stall_at && stall_left > 0) begin
      bus.cmd_ready = 1'b0;
      stall_left--;
      if (exp_cmd.size() > 0)
        check("stall_payload", {bus.cmd_payload_function_id, bus.cmd_payload_inputs_0,
                                bus.cmd_payload_inputs_1}, exp_cmd[0]);
    end else bus.cmd_ready = 1'b1;
    if (res_hold > 0) begin bus.res_ready = 1'b0; res_hold--; end
    else bus.res_ready = 1'b1;
    #1;
    cmd_hs  = bus.cmd_valid && bus.cmd_ready;
    got_cmd = {bus.cmd_payload_function_id, bus.cmd_payload_inputs_0, bus.cmd_payload_inputs_1};
    rsp_hs  = bus.rsp_valid && bus.rsp_ready;
    src_hs  = bus.src_valid && bus.src_ready;
    res_hs  = bus.res_valid && bus.res_ready;
    got_res = bus.res_data;
    if (last_op == 3'd3 && busy && !done && bus.res_valid && bus.rsp_valid)
      check("rsp_ready_while_res_full", bus.rsp_ready, 1'b0);
    if (done) begin done_cnt++; done_cyc = cyc_n; end
  endtask

  // Expected command/result stream for a job, with random A/B words.
  task automatic plan_job(input int unsigned a, b, c, input logic [7:0] m, k, n,
                          input bit timeout, input int unsigned rd_base);
    logic [31:0] w;
    exp_cmd.push_back({10'h000, 32'h0, 32'h0});
    for (int unsigned i = 0; i < a; i++) begin
      w = $urandom; src_q.push_back(w); exp_cmd.push_back({10'h001, i, w});
    end
    for (int unsigned i = 0; i < b; i++) begin
      w = $urandom; src_q.push_back(w); exp_cmd.push_back({10'h101, i, w});
    end
    exp_cmd.push_back({10'h002, 24'h0, m, 8'h0, k, 8'h0, n});
    if (!timeout)
      for (int unsigned i = 0; i < c; i++) begin
        w = (rd_base != 0) ? rd_base + i : $urandom;
        rd_q.push_back(w); exp_res.push_back(w);
        exp_cmd.push_back({10'h003, i, 32'h0});
      end
  endtask

  task automatic run_job(input int unsigned a, b, c, input logic [7:0] m, k, n, input bit exp_err);
    a_count = AB'(a); b_count = AB'(b); c_count = AB'(c);
    m_dim = m; k_dim = k; n_dim = n;
    done_cnt = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_after_start", busy, 1'b1);
    check("err_clear_on_start", err, 1'b0);
    for (int i = 0; i < 400 && done_cnt == 0; i++) tick();
    check("done_seen", done_cnt, 1);
    check("err", err, exp_err);
    if (exp_err) check("timeout_latency", done_cyc - last_hs_cyc, TMO);
    tick();
    check("done_one_cycle", done, 1'b0);
    check("busy_cleared", busy, 1'b0);
    for (int i = 0; i < 20 && (exp_res.size() > 0 || bus.res_valid); i++) tick();
    check("cmd_queue_empty", exp_cmd.size(), 0);
    check("res_queue_empty", exp_res.size(), 0);
    check("done_count", done_cnt, 1);
  endtask

  initial begin
    jobs[0] = '{2, 2, 1, 8'd1,   8'd2,   8'd1,   -1,     1'b0};
    jobs[1] = '{0, 0, 0, 8'd3,   8'd4,   8'd5,   -1,     1'b0};
    jobs[2] = '{1, 0, 2, 8'hff,  8'h80,  8'h01,  -1,     1'b0};
    jobs[3] = '{0, 3, 1, 8'd7,   8'd0,   8'd9,   -1,     1'b0};
    jobs[4] = '{3, 1, 4, 8'd2,   8'd3,   8'd4,   -1,     1'b0};
    jobs[5] = '{1, 1, 2, 8'd5,   8'd6,   8'd7,   10'h002, 1'b1};
    jobs[6] = '{1, 1, 2, 8'd1,   8'd1,   8'd1,   -1,     1'b0};

    bus.cmd_ready = 1'b0; bus.rsp_valid = 1'b0; bus.rsp_payload_outputs_0 = '0;
    bus.src_valid = 1'b0; bus.src_data = '0; bus.res_ready = 1'b1;

    tick(); tick();
    check("rst_cmd_valid", bus.cmd_valid, 1'b0);
    check("rst_rsp_ready", bus.rsp_ready, 1'b0);
    check("rst_res_valid", bus.res_valid, 1'b0);
    check("rst_src_ready", bus.src_ready, 1'b0);
    check("rst_busy_done_err", {busy, done, err}, 3'b000);
    check("rst_payload", {bus.cmd_payload_function_id, bus.cmd_payload_inputs_0,
                          bus.cmd_payload_inputs_1, bus.res_data}, '0);
    reset = 1'b0;
    tick();

    // Reference job with fixed words; 2nd WRITE held off for 5 cycles.
    exp_cmd.push_back({10'h000, 32'd0, 32'd0});
    exp_cmd.push_back({10'h001, 32'd0, 32'd11});
    exp_cmd.push_back({10'h001, 32'd1, 32'd22});
    exp_cmd.push_back({10'h101, 32'd0, 32'd33});
    exp_cmd.push_back({10'h101, 32'd1, 32'd44});
    exp_cmd.push_back({10'h002, 32'd1, 32'h00020001});
    exp_cmd.push_back({10'h003, 32'd0, 32'd0});
    src_q.push_back(32'd11); src_q.push_back(32'd22);
    src_q.push_back(32'd33); src_q.push_back(32'd44);
    rd_q.push_back(32'h5a5a0001); exp_res.push_back(32'h5a5a0001);
    stall_at = 2; stall_left = 5;
    run_job(2, 2, 1, 8'd1, 8'd2, 8'd1, 1'b0);
    check("stall_consumed", stall_left, 0);
    stall_at = -1;

    // Result back-pressure: consumer stalls 4 cycles after the first word.
    plan_job(1, 1, 3, 8'd2, 8'd2, 8'd2, 1'b0, 32'hA);
    res_stall_arm = 1'b1;
    run_job(1, 1, 3, 8'd2, 8'd2, 8'd2, 1'b0);

    for (int i = 0; i < 7; i++) begin
      mute_fid = jobs[i].mute;
      plan_job(jobs[i].a, jobs[i].b, jobs[i].c, jobs[i].m, jobs[i].k, jobs[i].n,
               jobs[i].exp_err, 0);
      run_job(jobs[i].a, jobs[i].b, jobs[i].c, jobs[i].m, jobs[i].k, jobs[i].n, jobs[i].exp_err);
      mute_fid = -1; muted_hit = 1'b0;
    end

    // Reset while waiting on the first B write response.
    mute_fid = 10'h101;
    plan_job(1, 2, 1, 8'd4, 8'd4, 8'd4, 1'b0, 0);
    a_count = AB'(1); b_count = AB'(2); c_count = AB'(1);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 200 && !muted_hit; i++) tick();
    check("reached_wrb_r", muted_hit, 1'b1);
    tick(); tick();
    check("in_wrb_r", {busy, bus.rsp_ready}, 2'b11);
    reset = 1'b1;
    #1;
    check("mid_rst_rsp_ready", bus.rsp_ready, 1'b0);
    check("mid_rst_cmd_res", {bus.cmd_valid, bus.res_valid, bus.src_ready}, 3'b000);
    check("mid_rst_busy", busy, 1'b0);
    exp_cmd.delete(); src_q.delete(); rd_q.delete(); exp_res.delete();
    cmd_hs = 1'b0; rsp_hs = 1'b0; src_hs = 1'b0; res_hs = 1'b0; rsp_owed = 1'b0;
    bus.rsp_valid = 1'b0; mute_fid = -1; muted_hit = 1'b0; last_op = '0;
    tick(); tick();
    reset = 1'b0;
    tick();
    plan_job(1, 2, 1, 8'd4, 8'd4, 8'd4, 1'b0, 0);
    run_job(1, 2, 1, 8'd4, 8'd4, 8'd4, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
